requant_sat_pipe: RTL and testbench
===================================

// Module: requant_sat_pipe
// PURPOSE
//  Parametrised requantiser: takes COLS signed accumulator+bias lanes, applies a runtime
//  arithmetic right shift with round-half-up, then clamps to BO_BW bits (signed or ReLU range).
//  Two-stage valid/ready pipeline between the bias adder and the activation writeback buffer.
// PARAMETERS
//  COLS    5   number of parallel lanes
//  AB_BW   25  input lane width (signed accumulator+bias)
//  BO_BW   8   output lane width (signed); BO_BW < AB_BW
//  SH_BW   5   width of shift amount
//  CNT_BW  16  saturation counter width (only with REQUANT_SAT_CNT_EN)
// PORTS
//  clk           in   1             clock, rising edge
//  rst           in   1             asynchronous active-high reset
//  i_valid       in   1             input beat valid
//  o_ready       out  1             block can accept input beat
//  i_acc_bias    in   AB_BW*COLS    lane i at [(i+1)*AB_BW-1 -: AB_BW], signed
//  i_shift       in   SH_BW         right-shift amount, sampled with the beat
//  i_relu_en     in   1             1: clamp to [0, 2^(BO_BW-1)-1]; sampled with the beat
//  o_valid       out  1             output beat valid
//  i_ready       in   1             downstream accepts output beat
//  o_bound_data  out  BO_BW*COLS    lane i at [(i+1)*BO_BW-1 -: BO_BW], signed
//  i_cnt_clr     in   1             sync clear of saturation counter (macro only)
//  o_sat_cnt     out  CNT_BW        beats with >=1 clipped lane (macro only)
// BEHAVIOUR
//  - Reset (async, rst=1): both stage valids 0, o_valid=0, o_bound_data=0, o_sat_cnt=0.
//    In-flight beats are dropped; first accept possible on the first edge after rst falls.
//  - Handshake: beat accepted on edge where i_valid && o_ready; output consumed on edge
//    where o_valid && i_ready. en2 = !v2 || i_ready; en1 = !v1 || en2; o_ready = en1
//    (combinational from i_ready). Full throughput 1 beat/cycle when i_ready held 1.
//  - Stall: while o_valid && !i_ready, o_bound_data held stable; no beat lost or duplicated.
//  - Latency: accepted beat appears on o_valid 2 cycles later when unstalled.
//  - Stage 1 (per lane, AB_BW+1 bit signed math): s = min(i_shift, AB_BW-1);
//    r = (x + (s>0 ? 2^(s-1) : 0)) >>> s. The extra bit prevents overflow on rounding.
//    Registers r per lane plus relu flag.
//  - Stage 2: lo = relu ? 0 : -2^(BO_BW-1); hi = 2^(BO_BW-1)-1.
//    y = r<lo ? lo : r>hi ? hi : r[BO_BW-1:0]. Registers y; lane "clipped" if r<lo or r>hi.
//  - Shift and relu are per beat: changing them between beats never affects in-flight beats.
//  - Output lane values are always within [lo,hi] of their own beat.
// CONFIGURATION
//  - REQUANT_SAT_CNT_EN defined: i_cnt_clr and o_sat_cnt ports exist. On each output
//    handshake where any lane of the beat was clipped, o_sat_cnt += 1, saturating at
//    2^CNT_BW-1 (no wrap). i_cnt_clr=1 clears to 0 on next edge; clear wins over
//    simultaneous increment. Clipped flag travels with the beat in stage 2.
//  - Not defined: ports i_cnt_clr/o_sat_cnt absent; no counter or clip-flag logic; datapath
//    and timing identical.
// TESTING
//  1 Pass-through: shift=0, relu=0, lanes {100,-100,127,-128,0} -> same values, o_valid 2
//    cycles after accept.
//  2 Rounding: shift=4, lanes {24,23,-24,-25,8} -> {2,1,-1,-2,1} (half rounds toward +inf).
//  3 Saturation: shift=0, relu=0, lanes {300,-300,2^24-1,-2^24,128} -> {127,-128,127,-128,127};
//    relu=1 same lanes -> {127,0,127,0,127}; counter +1 per beat (macro).
//  4 Backpressure: stream 8 beats with incrementing data, i_ready toggling 1010... -> all 8
//    out in order, no duplicates; o_ready=0 only while both stages full and i_ready=0.
//  5 Reset mid-stream: assert rst with 2 beats in flight -> o_valid=0, data=0 asynchronously;
//    no stale beat emitted after release.
//  6 Counter (macro): CNT_BW=2, 5 clipping beats -> o_sat_cnt stops at 3; i_cnt_clr coincident
//    with clipping handshake -> 0.

Source files
------------

// File: rtl/requant_sat_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : requant_sat_pipe                                              |
// | Purpose  : Requantiser between the bias adder and the activation         |
// |            writeback buffer. Each of COLS signed lanes is arithmetically |
// |            right-shifted by a per-beat amount with round-half-up, then   |
// |            clamped to a signed BO_BW range, or to [0, max] in ReLU mode. |
// |            Two-stage valid/ready pipeline: stage 1 shift+round, stage 2  |
// |            clamp.                                                        |
// | Ports    : clk, rst (async, active-high)                                 |
// |            i_valid/o_ready   - input beat handshake                      |
// |            i_acc_bias        - COLS x AB_BW signed lanes, lane 0 at LSBs |
// |            i_shift           - right-shift amount, captured with beat    |
// |            i_relu_en         - ReLU clamp select, captured with beat     |
// |            o_valid/i_ready   - output beat handshake                     |
// |            o_bound_data      - COLS x BO_BW signed lanes, lane 0 at LSBs |
// |            i_cnt_clr         - sync clear of saturation counter (*)      |
// |            o_sat_cnt         - count of beats with a clipped lane (*)    |
// | Macro    : REQUANT_SAT_CNT_EN - enables the (*) ports, the per-beat clip  |
// |            flag and the saturating clip counter.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module requant_sat_pipe #(
  parameter int COLS   = 5,
  parameter int AB_BW  = 25,
  parameter int BO_BW  = 8,
  parameter int SH_BW  = 5,
  parameter int CNT_BW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [AB_BW*COLS-1:0] i_acc_bias,
  input  logic [SH_BW-1:0]      i_shift,
  input  logic                  i_relu_en,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BO_BW*COLS-1:0] o_bound_data
`ifdef REQUANT_SAT_CNT_EN
  ,
  input  logic                  i_cnt_clr,
  output logic [CNT_BW-1:0]     o_sat_cnt
`endif
);

  // Stage-1 math is one bit wider than the input so that adding the rounding
  // constant to a lane near full scale cannot overflow.
  localparam int EW   = AB_BW + 1;
  localparam int SMAX = AB_BW - 1;

  // Clamp limits, expressed at the wide stage-1 width so comparisons are
  // exact. ~HI == -HI-1 == -2^(BO_BW-1) in two's complement.
  localparam logic signed [EW-1:0] C_HI = EW'((2 ** (BO_BW - 1)) - 1);
  localparam logic signed [EW-1:0] C_LO = ~C_HI;

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic v1_q;
  logic v2_q;
  logic relu1_q;
  logic w_en1;
  logic w_en2;
  logic w_ld1;
  logic w_ld2;

  // A stage may advance when it is empty or the stage after it is advancing;
  // o_ready therefore depends combinationally on i_ready.
  assign w_en2   = !v2_q || i_ready;
  assign w_en1   = !v1_q || w_en2;
  assign w_ld1   = w_en1 && i_valid;
  assign w_ld2   = w_en2 && v1_q;
  assign o_ready = w_en1;
  assign o_valid = v2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      relu1_q <= 1'b0;
    end else begin
      if (w_en1) begin
        v1_q <= i_valid;
      end
      if (w_en2) begin
        v2_q <= v1_q;
      end
      // The ReLU select travels with its beat so later changes on i_relu_en
      // never touch a beat already in flight.
      if (w_ld1) begin
        relu1_q <= i_relu_en;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-1 shared terms: clamped shift and rounding constant
  // ---------------------------------------------------------------------------
  logic [SH_BW-1:0]     w_shift;
  logic signed [EW-1:0] w_rnd;

  // Shifting by more than AB_BW-1 would leave only sign bits anyway; clamping
  // keeps the rounding constant inside the wide datapath.
  always_comb begin
    if (int'(i_shift) > SMAX) begin
      w_shift = SH_BW'(SMAX);
    end else begin
      w_shift = i_shift;
    end
  end

  // Half an LSB of the result, so that ties round toward +infinity once the
  // arithmetic shift floors the sum.
  always_comb begin
    w_rnd = '0;
    if (w_shift != '0) begin
      w_rnd = EW'(1) << (w_shift - SH_BW'(1));
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-2 shared term: lower clamp of the beat currently in stage 1
  // ---------------------------------------------------------------------------
  logic signed [EW-1:0] w_lo;

  assign w_lo = relu1_q ? '0 : C_LO;

`ifdef REQUANT_SAT_CNT_EN
  logic [COLS-1:0] w_lane_clip;
`endif

  // ---------------------------------------------------------------------------
  // Per-lane datapath
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < COLS; g++) begin : g_lane
    logic [AB_BW-1:0]     w_lane_in;
    logic signed [EW-1:0] w_x;
    logic signed [EW-1:0] w_sum;
    logic signed [EW-1:0] r1_d;
    logic signed [EW-1:0] r1_q;
    logic                 w_below;
    logic                 w_above;
    logic [BO_BW-1:0]     y2_d;
    logic [BO_BW-1:0]     y2_q;

    assign w_lane_in = i_acc_bias[(g+1)*AB_BW-1 -: AB_BW];
    assign w_x       = $signed({w_lane_in[AB_BW-1], w_lane_in});
    assign w_sum     = w_x + w_rnd;
    assign r1_d      = w_sum >>> w_shift;

    // Clamp compares the full-width rounded value; only in-range values are
    // truncated to BO_BW bits, which is then lossless.
    assign w_below = (r1_q < w_lo);
    assign w_above = (r1_q > C_HI);

    always_comb begin
      if (w_below) begin
        y2_d = w_lo[BO_BW-1:0];
      end else if (w_above) begin
        y2_d = C_HI[BO_BW-1:0];
      end else begin
        y2_d = r1_q[BO_BW-1:0];
      end
    end

`ifdef REQUANT_SAT_CNT_EN
    assign w_lane_clip[g] = w_below || w_above;
`endif

    // Data registers only load alongside a valid beat, so a stalled output
    // holds its value until it is consumed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r1_q <= '0;
        y2_q <= '0;
      end else begin
        if (w_ld1) begin
          r1_q <= r1_d;
        end
        if (w_ld2) begin
          y2_q <= y2_d;
        end
      end
    end

    assign o_bound_data[(g+1)*BO_BW-1 -: BO_BW] = y2_q;
  end

  // ---------------------------------------------------------------------------
  // Saturation counter
  // ---------------------------------------------------------------------------
`ifdef REQUANT_SAT_CNT_EN
  logic              clip2_q;
  logic [CNT_BW-1:0] sat_cnt_q;
  logic [CNT_BW-1:0] sat_cnt_d;

  // Beat-level clip flag rides in stage 2 next to the clamped data so it is
  // counted exactly once, at the output handshake of its own beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip2_q <= 1'b0;
    end else if (w_ld2) begin
      clip2_q <= |w_lane_clip;
    end
  end

  // Clear has priority over a coincident increment; the count sticks at
  // all-ones instead of wrapping.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (i_cnt_clr) begin
      sat_cnt_d = '0;
    end else if (v2_q && i_ready && clip2_q && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign o_sat_cnt = sat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_requant_sat_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_requant_sat_pipe                                           |
// | Purpose  : Directed self-checking bench for requant_sat_pipe: reset      |
// |            state, pass-through, rounding, shift clamp, saturation with   |
// |            and without ReLU, backpressure ordering, mid-stream reset and |
// |            (with REQUANT_SAT_CNT_EN) the saturating clip counter.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_requant_sat_pipe;

  localparam int COLS  = 5;
  localparam int AB_BW = 25;
  localparam int BO_BW = 8;
  localparam int SH_BW = 5;
`ifdef REQUANT_SAT_CNT_EN
  localparam int CNT_BW = 2;
`else
  localparam int CNT_BW = 16;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_valid;
  logic                  o_ready;
  logic [AB_BW*COLS-1:0] i_acc_bias;
  logic [SH_BW-1:0]      i_shift;
  logic                  i_relu_en;
  logic                  o_valid;
  logic                  i_ready;
  logic [BO_BW*COLS-1:0] o_bound_data;
`ifdef REQUANT_SAT_CNT_EN
  logic                  i_cnt_clr;
  logic [CNT_BW-1:0]     o_sat_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Backpressure model state
  int   sent;
  int   rcvd;
  logic m_v1;
  logic m_v2;
  logic n_v1;
  logic n_v2;
  logic exp_rdy;
  logic stale;

  requant_sat_pipe #(
    .COLS   (COLS),
    .AB_BW  (AB_BW),
    .BO_BW  (BO_BW),
    .SH_BW  (SH_BW),
    .CNT_BW (CNT_BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_acc_bias   (i_acc_bias),
    .i_shift      (i_shift),
    .i_relu_en    (i_relu_en),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_bound_data (o_bound_data)
`ifdef REQUANT_SAT_CNT_EN
    ,
    .i_cnt_clr    (i_cnt_clr),
    .o_sat_cnt    (o_sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, finish required");
    $fatal(1);
  end

  function automatic logic [AB_BW*COLS-1:0] pk_in(input int a0, input int a1,
                                                  input int a2, input int a3,
                                                  input int a4);
    return {AB_BW'(a4), AB_BW'(a3), AB_BW'(a2), AB_BW'(a1), AB_BW'(a0)};
  endfunction

  function automatic logic [BO_BW*COLS-1:0] pk_out(input int a0, input int a1,
                                                   input int a2, input int a3,
                                                   input int a4);
    return {BO_BW'(a4), BO_BW'(a3), BO_BW'(a2), BO_BW'(a1), BO_BW'(a0)};
  endfunction

  // Backpressure stream: beat k lane j = 10k+j, lane 4 negated.
  function automatic logic [AB_BW*COLS-1:0] bp_in(input int k);
    return pk_in(10*k, 10*k+1, 10*k+2, 10*k+3, -(10*k+4));
  endfunction

  function automatic logic [BO_BW*COLS-1:0] bp_out(input int k);
    return pk_out(10*k, 10*k+1, 10*k+2, 10*k+3, -(10*k+4));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one beat into an empty pipe with i_ready=1 and check latency/value.
  // Inputs are scrambled right after acceptance so a design that failed to
  // capture shift/relu with the beat would be caught. Entry/exit: 1ns after
  // a rising edge.
  task automatic one_beat(input string tag, input logic [AB_BW*COLS-1:0] d,
                          input logic [SH_BW-1:0] sh, input logic relu,
                          input logic [BO_BW*COLS-1:0] exp);
    i_valid    = 1'b1;
    i_acc_bias = d;
    i_shift    = sh;
    i_relu_en  = relu;
    i_ready    = 1'b1;
    #1;
    chk({tag, "_ordy"}, 64'(o_ready), 64'(1));
    @(posedge clk); #1;
    i_valid    = 1'b0;
    i_acc_bias = '1;
    i_shift    = SH_BW'(31);
    i_relu_en  = ~relu;
    chk({tag, "_lat1"}, 64'(o_valid), 64'(0));
    @(posedge clk); #1;
    chk({tag, "_lat2"}, 64'(o_valid), 64'(1));
    chk({tag, "_data"}, 64'(o_bound_data), 64'(exp));
    @(posedge clk); #1;
    chk({tag, "_drain"}, 64'(o_valid), 64'(0));
  endtask

  initial begin
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_acc_bias = '0;
    i_shift    = '0;
    i_relu_en  = 1'b0;
    i_ready    = 1'b1;
`ifdef REQUANT_SAT_CNT_EN
    i_cnt_clr  = 1'b0;
`endif

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", 64'(o_valid), 64'(0));
    chk("rst_data",   64'(o_bound_data), 64'(0));
    chk("rst_ordy",   64'(o_ready), 64'(1));
`ifdef REQUANT_SAT_CNT_EN
    chk("rst_cnt",    64'(o_sat_cnt), 64'(0));
`endif
    rst = 1'b0;

    // ---------------- pass-through ----------------
    one_beat("pass", pk_in(100, -100, 127, -128, 0), SH_BW'(0), 1'b0,
             pk_out(100, -100, 127, -128, 0));

    // ---------------- rounding ----------------
    one_beat("rnd4", pk_in(24, 23, -24, -25, 8), SH_BW'(4), 1'b0,
             pk_out(2, 1, -1, -2, 1));
    one_beat("rnd1", pk_in(3, -3, 1, -1, 5), SH_BW'(1), 1'b0,
             pk_out(2, -1, 1, 0, 3));
    // Shift 31 clamps to 24; lane 0 needs the extra bit to round correctly.
    one_beat("shclamp", pk_in(16777215, -16777216, 8388608, 0, -8388608),
             SH_BW'(31), 1'b0, pk_out(1, -1, 1, 0, 0));

    // ---------------- saturation ----------------
    one_beat("sat", pk_in(300, -300, 16777215, -16777216, 128), SH_BW'(0), 1'b0,
             pk_out(127, -128, 127, -128, 127));
    one_beat("relu", pk_in(300, -300, 16777215, -16777216, 128), SH_BW'(0), 1'b1,
             pk_out(127, 0, 127, 0, 127));
    one_beat("relu_in", pk_in(5, -1, 0, 126, -128), SH_BW'(0), 1'b1,
             pk_out(5, 0, 0, 126, 0));

    // ---------------- backpressure ----------------
    sent = 0;
    rcvd = 0;
    m_v1 = 1'b0;
    m_v2 = 1'b0;
    i_shift   = '0;
    i_relu_en = 1'b0;
    for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
      i_ready    = ((cyc % 2) == 0);
      i_valid    = (sent < 8);
      i_acc_bias = bp_in(sent);
      #1;
      exp_rdy = !(m_v1 && m_v2 && !i_ready);
      chk("bp_ordy",   64'(o_ready), 64'(exp_rdy));
      chk("bp_ovalid", 64'(o_valid), 64'(m_v2));
      if (o_valid) begin
        chk("bp_data", 64'(o_bound_data), 64'(bp_out(rcvd)));
        if (i_ready) rcvd++;
      end
      n_v2 = (!m_v2 || i_ready) ? m_v1 : m_v2;
      n_v1 = exp_rdy ? i_valid : m_v1;
      if (i_valid && exp_rdy) sent++;
      m_v1 = n_v1;
      m_v2 = n_v2;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("bp_sent", 64'(sent), 64'(8));
    chk("bp_rcvd", 64'(rcvd), 64'(8));
    @(posedge clk); #1;
    chk("bp_empty", 64'(o_valid), 64'(0));

    // ---------------- reset mid-stream ----------------
    i_ready    = 1'b0;
    i_valid    = 1'b1;
    i_acc_bias = pk_in(1, 2, 3, 4, 5);
    i_shift    = '0;
    i_relu_en  = 1'b0;
    @(posedge clk); #1;
    i_acc_bias = pk_in(6, 7, 8, 9, 10);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("mr_pre_valid", 64'(o_valid), 64'(1));
    chk("mr_pre_data",  64'(o_bound_data), 64'(pk_out(1, 2, 3, 4, 5)));
    #3;
    rst = 1'b1;
    #1;
    chk("mr_async_valid", 64'(o_valid), 64'(0));
    chk("mr_async_data",  64'(o_bound_data), 64'(0));
    @(posedge clk); #1;
    rst     = 1'b0;
    i_ready = 1'b1;
    stale   = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_valid) stale = 1'b1;
    end
    chk("mr_no_stale", 64'(stale), 64'(0));
    one_beat("mr_after", pk_in(-7, 7, 200, -200, 64), SH_BW'(1), 1'b0,
             pk_out(-3, 4, 100, -100, 32));

`ifdef REQUANT_SAT_CNT_EN
    // ---------------- saturation counter ----------------
    i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    i_cnt_clr = 1'b0;
    chk("cnt_clr", 64'(o_sat_cnt), 64'(0));
    one_beat("cnt_noclip", pk_in(100, -100, 127, -128, 0), SH_BW'(0), 1'b0,
             pk_out(100, -100, 127, -128, 0));
    chk("cnt_noclip_val", 64'(o_sat_cnt), 64'(0));
    for (int k = 0; k < 5; k++) begin
      one_beat("cnt_clip", pk_in(300, 0, 0, 0, 0), SH_BW'(0), 1'b0,
               pk_out(127, 0, 0, 0, 0));
    end
    chk("cnt_sat", 64'(o_sat_cnt), 64'(3));
    // Clear coincident with a clipping handshake: clear wins.
    i_valid    = 1'b1;
    i_acc_bias = pk_in(0, -300, 0, 0, 0);
    i_shift    = '0;
    i_relu_en  = 1'b0;
    i_ready    = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    chk("cnt_coinc_valid", 64'(o_valid), 64'(1));
    i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    i_cnt_clr = 1'b0;
    chk("cnt_coinc", 64'(o_sat_cnt), 64'(0));
    one_beat("cnt_relu_clip", pk_in(-1, 0, 0, 0, 0), SH_BW'(0), 1'b1,
             pk_out(0, 0, 0, 0, 0));
    chk("cnt_one", 64'(o_sat_cnt), 64'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
